// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the CPU data-memory port.
// Accepts one load/store at a time, inserts LATENCY wait states, commits
// byte-enabled stores and returns load data or an error with a one-cycle
// response pulse. Used to exercise the pipeline's memory stall path.
module dmem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DAT_WIDTH-1:0]  wdata_i,
    input  logic [3:0]            be_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DAT_WIDTH-1:0]  rdata_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    // Depth expressed in the width of the word index, for an unsigned compare
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W  = (ADDR_WIDTH-2)'(DEPTH);
    localparam logic [3:0]            CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DAT_WIDTH-1:0]   wdata_q;
    logic [3:0]             be_q;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic [DAT_WIDTH-1:0]   rdata_q, rdata_d;

    logic                   accept;
    logic                   enter_resp;
    logic                   wr_en;

    // Transaction currently being serviced: the live inputs while IDLE (so a
    // zero-latency access can complete on its accept edge), else the held copy.
    logic                   cur_we;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [DAT_WIDTH-1:0]   cur_wdata;
    logic [3:0]             cur_be;
    logic [ADDR_WIDTH-3:0]  word_idx;
    logic [IDX_W-1:0]       mem_idx;
    logic                   cur_err;
    logic [DAT_WIDTH-1:0]   rd_word;

    assign accept    = req_i && (state_q == IDLE);
    assign cur_we    = (state_q == IDLE) ? we_i    : we_q;
    assign cur_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
    assign cur_be    = (state_q == IDLE) ? be_i    : be_q;

    // Misaligned or out-of-range addresses error out instead of aliasing
    assign word_idx  = cur_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign cur_err   = (cur_addr[1:0] != 2'b00) || (word_idx >= DEPTH_W);

    // Gate with rst so nothing is written while the block is held in reset
    assign wr_en     = enter_resp && cur_we && !cur_err && !rst;

    // One byte-wide array per lane so each byte enable maps onto its own RAM
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];

        // Byte-lane write on the edge entering RESP
        always_ff @(posedge clk) begin
            if (wr_en && cur_be[gi]) begin
                mem[mem_idx] <= cur_wdata[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = mem[mem_idx];
    end

    // Next-state, wait counter and response data
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (!cur_we && !cur_err) ? rd_word : '0;
        end

        // Pulse is taken from the registered RESP state, so it appears the
        // cycle after rdata/err were loaded and they are stable under it
        rvalid_d = (state_q == RESP);
    end

    // State, holding registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 4) share a clock
// and reset. Table-driven transactions plus hand sequences for the handshake
// and reset-in-WAIT cases; responses are checked through a scoreboard queue.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req, we, ready, rvalid, err, busy;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [3:0]  be    [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 0 : 4);
        dmem_responder #(
            .ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req[gi]),
            .we_i     (we[gi]),
            .addr_i   (addr[gi]),
            .wdata_i  (wdata[gi]),
            .be_i     (be[gi]),
            .ready_o  (ready[gi]),
            .rvalid_o (rvalid[gi]),
            .rdata_o  (rdata[gi]),
            .err_o    (err[gi]),
            .busy_o   (busy[gi])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    typedef struct {
        int          k;
        int          cyc_due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          k;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rvalid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rvalid[k] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("spurious_rvalid", {31'b0, rvalid[k]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("resp_inst",  k, e.k);
                    check("resp_cycle", cyc, e.cyc_due);
                    check("resp_rdata", rdata[k], e.rdata);
                    check("resp_err",   {31'b0, err[k]}, {31'b0, e.err});
                    $display("resp inst=%0d cyc=%0d rdata=%h err=%b", k, cyc, rdata[k], err[k]);
                end
            end
        end
    end

    task automatic wait_ready(int k);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", {31'b0, ready[k]}, 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("resp_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    // One complete transaction on instance k; response is expected LATENCY+1
    // edges after the accept edge and rdata/err must hold afterwards
    task automatic txn(vec_t v);
        exp_t e;
        int   k = v.k;
        @(negedge clk);
        wait_ready(k);
        req[k]   = 1'b1;
        we[k]    = v.we;
        addr[k]  = v.addr;
        wdata[k] = v.wdata;
        be[k]    = v.be;
        e.k       = k;
        e.cyc_due = cyc + lat_of(k) + 2;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        sbq.push_back(e);
        $display("txn inst=%0d we=%b addr=%h wdata=%h be=%b", k, v.we, v.addr, v.wdata, v.be);
        @(negedge clk);
        req[k]   = 1'b0;
        we[k]    = 1'($urandom);
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        be[k]    = 4'($urandom);
        wait_drain();
        @(negedge clk);
        @(negedge clk);
        check("rdata_hold", rdata[k], v.exp_rdata);
        check("err_hold",   {31'b0, err[k]}, {31'b0, v.exp_err});
    endtask

    vec_t vt [21];

    initial begin
        req = '0;
        we  = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = '0;
            wdata[k] = '0;
            be[k]    = '0;
        end

        //            k  we    addr          wdata         be       exp_rdata     exp_err
        vt[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0};
        vt[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF,  1'b0};
        vt[2]  = '{0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0,          1'b0};
        vt[3]  = '{0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0,          1'b0};
        vt[4]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_33DD,  1'b0};
        vt[5]  = '{0, 1'b0, 32'h0000_0022, 32'h0,         4'b1111, 32'h0,          1'b1};
        vt[6]  = '{0, 1'b0, 32'h0000_1000, 32'h0,         4'b1111, 32'h0,          1'b1};
        vt[7]  = '{0, 1'b1, 32'h0000_0022, 32'h0000_0005, 4'b1111, 32'h0,          1'b1};
        vt[8]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h11BB_33DD,  1'b0};
        vt[9]  = '{0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 32'h0,          1'b0};
        vt[10] = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         4'b1111, 32'hCAFE_F00D,  1'b0};
        vt[11] = '{0, 1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0};
        vt[12] = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         4'b1111, 32'hCAFE_F00D,  1'b0};
        vt[13] = '{0, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0,          1'b0};
        vt[14] = '{0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0,          1'b1};
        vt[15] = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0102_0304,  1'b0};
        vt[16] = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h11BB_33DD,  1'b0};
        vt[17] = '{1, 1'b1, 32'h0000_0008, 32'h0A0B_0C0D, 4'b1111, 32'h0,          1'b0};
        vt[18] = '{1, 1'b0, 32'h0000_0008, 32'h0,         4'b1111, 32'h0A0B_0C0D,  1'b0};
        vt[19] = '{2, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'b1111, 32'h0,          1'b0};
        vt[20] = '{2, 1'b0, 32'h0000_0040, 32'h0,         4'b1111, 32'h0,          1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ready",  {31'b0, ready[k]},  32'd1);
            check("rst_busy",   {31'b0, busy[k]},   32'd0);
            check("rst_rvalid", {31'b0, rvalid[k]}, 32'd0);
            check("rst_rdata",  rdata[k],           32'd0);
            check("rst_err",    {31'b0, err[k]},    32'd0);
        end

        // Table-driven transactions
        for (int i = 0; i < 21; i++) txn(vt[i]);

        // Handshake, LATENCY=0: req held for 10 cycles, accepts every other edge
        begin
            int c0;
            @(negedge clk);
            wait_ready(1);
            c0 = cyc;
            req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h100; wdata[1] = 32'h0; be[1] = 4'hF;
            for (int j = 0; j < 5; j++) begin
                exp_t e;
                e.k = 1; e.cyc_due = c0 + 2*j + 2; e.rdata = 32'h0; e.err = 1'b0;
                sbq.push_back(e);
            end
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("hs_ready", {31'b0, ready[1]}, (i % 2 == 1) ? 32'd1 : 32'd0);
                check("hs_busy",  {31'b0, busy[1]},  (i % 2 == 0) ? 32'd1 : 32'd0);
                $display("hs cycle=%0d ready=%b busy=%b", i, ready[1], busy[1]);
            end
            req[1] = 1'b0;
            wait_drain();
        end

        // Reset asserted in WAIT (LATENCY=4): store abandoned, no response
        begin
            vec_t v;
            @(negedge clk);
            wait_ready(2);
            req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h1234_5678; be[2] = 4'hF;
            @(negedge clk);
            req[2] = 1'b0;
            check("rw_busy", {31'b0, busy[2]}, 32'd1);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rw_async_ready", {31'b0, ready[2]}, 32'd1);
            check("rw_async_busy",  {31'b0, busy[2]},  32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("rw_no_rvalid", {31'b0, rvalid[2]}, 32'd0);
            end
            check("rw_ready", {31'b0, ready[2]}, 32'd1);
            v = '{2, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 32'h0, 1'b0};
            txn(v);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
